sr_mc_control: RTL
==================

# sr_mc_control

Multi-cycle control FSM for the schoolRISCV core. It sequences one instruction at a time through fetch, decode and execute over a shared, variable-latency instruction memory port. It consumes the decoded fields (opcode, funct3, funct7, rd) and the ALU zero flag, and drives the PC, instruction-register, register-file and ALU control strobes. It replaces the single-cycle combinational control unit when the core runs against a memory with wait states.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports (clock and reset first):
- `clk` input, 1: the only clock.
- `rst` input, 1: reset, **synchronous, active-high**.
- `cmdOp` input, 7: opcode field of the instruction register.
- `cmdF3` input, 3: funct3 field.
- `cmdF7` input, 7: funct7 field.
- `rd` input, 5: destination register index.
- `aluZero` input, 1: ALU result == 0.
- `imem_req` output, 1: fetch request, held until acknowledged.
- `imem_ack` input, 1: instruction data valid this cycle.
- `ir_we` output, 1: load the instruction register.
- `pc_we` output, 1: update the PC.
- `pc_src` output, 2: PC source. PLUS4=0, BRANCH=1 (pc+immB), JAL=2 (pc+immJ).
- `reg_we` output, 1: register-file write enable.
- `wd_src` output, 2: write-data source. ALU=0, IMMU=1, PC4=2.
- `alu_src_imm` output, 1: ALU operand B is immI.
- `alu_ctrl` output, 3: ADD=0, OR=1, SRL=2, SLTU=3, SUB=4.
- `halted` output, 1: an illegal instruction was decoded.
- `retired_cnt` output, CNT_W: number of retired instructions.
- `stall_cnt` output, CNT_W: number of fetch wait cycles.

## Operation
- States: FETCH, DECODE, EXEC, HALT. Reset state is FETCH.
- **FETCH**
  - `imem_req`=1.
  - If `imem_ack`: `ir_we`=1 combinationally and the FSM moves to DECODE.
  - Otherwise it stays in FETCH.
- **DECODE**: one cycle for the register-file read; all strobes are 0. Next state is EXEC unless the opcode is illegal, in which case it goes to HALT.
- **EXEC**: `pc_we`=1 and next state is FETCH. Decoded per instruction:
  - **R-type** (0110011): ADD, SUB (F7=0100000), OR, SRL, SLTU. `reg_we`=1, `wd_src`=ALU, `pc_src`=PLUS4.
  - **ADDI** (0010011, F3=000): as R-type with `alu_src_imm`=1 and ADD.
  - **LUI** (0110111): `wd_src`=IMMU.
  - **BEQ/BNE** (1100011, F3=000/001): `alu_ctrl`=SUB, `reg_we`=0, `pc_src`=BRANCH when the branch is taken (BEQ: `aluZero`, BNE: !`aluZero`), otherwise PLUS4.
  - **JAL** (1101111): `reg_we`=1, `wd_src`=PC4, `pc_src`=JAL.
- Any other opcode or funct combination is illegal.
- `reg_we` is forced to 0 when `rd`==0.
- **HALT**: absorbing. `halted`=1 and all strobes are 0; only `rst` leaves it.
- `imem_ack` is ignored outside FETCH.

## Timing
- While `rst` is high, every output is 0: `imem_req`, `ir_we`, `pc_we`, `reg_we`, `halted`, the counters, and `pc_src`/`wd_src`/`alu_ctrl`/`alu_src_imm`.
- `imem_req`=1 in the first cycle after `rst` deasserts.
- With zero-wait memory an instruction takes 3 cycles (FETCH, DECODE, EXEC). Each FETCH wait cycle adds 1.
- Strobes are decoded from the current state plus inputs; they are not registered.
- Reset asserted in EXEC suppresses that cycle's `pc_we`/`reg_we`.
- Reset asserted during a pending fetch drops `imem_req` the same cycle.
- Counters wrap modulo 2^CNT_W.

## Configuration
- **`SR_MC_PERF_CNT_EN` defined**:
  - `retired_cnt` increments in every EXEC cycle.
  - `stall_cnt` increments in every FETCH cycle with `imem_req`=1 and `imem_ack`=0.
- **Not defined**: the ports remain, tied to 0, and no counter registers are built.

## Structure
- Package `sr_mc_pkg` holds:
  - the state enum;
  - the `alu_ctrl`, `pc_src` and `wd_src` enums;
  - the opcode, funct3 and funct7 constants.
- Sub-module `sr_mc_alu_dec`: combinational mapping of opcode/F3/F7 to `alu_ctrl`, `alu_src_imm` and an illegal flag. It is shared between DECODE (illegal check) and EXEC.

## Test plan
- **Reset**: hold `rst` 3 cycles → all outputs 0. First cycle after release → `imem_req`=1.
- **ADDI**: 0x00500093 with immediate ack.
  - Cycle 0: `ir_we`=1.
  - Cycle 1: all strobes 0.
  - Cycle 2: `reg_we`=1, `alu_src_imm`=1, `alu_ctrl`=ADD, `pc_we`=1, `pc_src`=0.
  - Cycle 3: `imem_req`=1.
- **Wait states**: `imem_ack` delayed 4 cycles → `imem_req` high 5 cycles, `ir_we` only in the 5th. With the macro, `stall_cnt`=4.
- **Branches**:
  - BEQ 0x00000463 with `aluZero`=1 → `pc_src`=BRANCH, `reg_we`=0.
  - BNE 0x00001463 with `aluZero`=1 → `pc_src`=PLUS4.
- **x0 write and JAL**:
  - ADDI to x0, 0x00500013 → `reg_we`=0, `pc_we`=1.
  - JAL 0x008000EF → `reg_we`=1, `wd_src`=PC4, `pc_src`=JAL.
- **Illegal instruction**: 0x0000007F → `halted`=1 after DECODE. `imem_req` stays 0 for 20 cycles and clears only on `rst`. With the macro, `retired_cnt` equals the number of instructions executed before it.

Source files
------------

// File: rtl/sr_mc_pkg.sv
// Shared types and encoding constants for the schoolRISCV multi-cycle control FSM.
package sr_mc_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_OR   = 3'd1,
    ALU_SRL  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_SUB  = 3'd4
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_IMMU = 2'd1,
    WD_PC4  = 2'd2
  } wd_src_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/sr_mc_alu_dec.sv
// Opcode/funct decoder: ALU operation, immediate-operand select and illegal flag.
module sr_mc_alu_dec
  import sr_mc_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  output alu_ctrl_t  alu_ctrl,
  output logic       alu_src_imm,
  output logic       illegal
);

  // Anything not explicitly recognised is flagged illegal so DECODE can halt.
  always_comb begin
    alu_ctrl    = ALU_ADD;
    alu_src_imm = 1'b0;
    illegal     = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD:  alu_ctrl = ALU_ADD;
            F3_OR:   alu_ctrl = ALU_OR;
            F3_SRL:  alu_ctrl = ALU_SRL;
            F3_SLTU: alu_ctrl = ALU_SLTU;
            default: illegal  = 1'b1;
          endcase
        end else if (f7 == F7_SUB && f3 == F3_ADD) begin
          alu_ctrl = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ADDI: begin
        if (f3 == F3_ADD) alu_src_imm = 1'b1;
        else              illegal     = 1'b1;
      end
      OP_LUI, OP_JAL: begin
        alu_ctrl = ALU_ADD;
      end
      OP_BRANCH: begin
        alu_ctrl = ALU_SUB;
        if (f3 != F3_BEQ && f3 != F3_BNE) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sr_mc_control.sv
// Multi-cycle FETCH/DECODE/EXEC/HALT control for schoolRISCV over a wait-state memory.
// Optional feature macro: SR_MC_PERF_CNT_EN builds the retired/stall counters;
// without it the counter ports are tied to zero.
module sr_mc_control
  import sr_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       cmdOp,
  input  logic [2:0]       cmdF3,
  input  logic [6:0]       cmdF7,
  input  logic [4:0]       rd,
  input  logic             aluZero,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wd_src,
  output logic             alu_src_imm,
  output logic [2:0]       alu_ctrl,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t    state;
  state_t    state_next;
  alu_ctrl_t dec_alu;
  logic      dec_imm;
  logic      dec_illegal;
  logic      writes_rd;
  logic      br_taken;

  sr_mc_alu_dec u_alu_dec (
    .op          (cmdOp),
    .f3          (cmdF3),
    .f7          (cmdF7),
    .alu_ctrl    (dec_alu),
    .alu_src_imm (dec_imm),
    .illegal     (dec_illegal)
  );

  // State register; reset returns to FETCH.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  // Next state and unregistered strobes; reset forces every strobe low in the same cycle.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_PLUS4;
    reg_we      = 1'b0;
    wd_src      = WD_ALU;
    alu_src_imm = 1'b0;
    alu_ctrl    = ALU_ADD;
    halted      = 1'b0;
    writes_rd   = 1'b0;
    br_taken    = (cmdF3 == F3_BEQ) ? aluZero : !aluZero;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = dec_illegal ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        pc_we       = 1'b1;
        state_next  = ST_FETCH;
        alu_ctrl    = dec_alu;
        alu_src_imm = dec_imm;
        case (cmdOp)
          OP_RTYPE, OP_ADDI: writes_rd = 1'b1;
          OP_LUI: begin
            writes_rd = 1'b1;
            wd_src    = WD_IMMU;
          end
          OP_JAL: begin
            writes_rd = 1'b1;
            wd_src    = WD_PC4;
            pc_src    = PC_JAL;
          end
          OP_BRANCH: begin
            if (br_taken) pc_src = PC_BRANCH;
          end
          default: writes_rd = 1'b0;
        endcase
        reg_we = writes_rd && (rd != 5'd0);
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_next = ST_FETCH;
    endcase
    if (rst) begin
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = PC_PLUS4;
      reg_we      = 1'b0;
      wd_src      = WD_ALU;
      alu_src_imm = 1'b0;
      alu_ctrl    = ALU_ADD;
      halted      = 1'b0;
    end
  end

`ifdef SR_MC_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] stall_q;

  // Count EXEC cycles as retirements and unacknowledged fetch requests as stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (state == ST_EXEC)       retired_q <= retired_q + CNT_W'(1);
      if (imem_req && !imem_ack)  stall_q   <= stall_q + CNT_W'(1);
    end
  end

  assign retired_cnt = rst ? '0 : retired_q;
  assign stall_cnt   = rst ? '0 : stall_q;
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule
